// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle control unit.
// Holds the FSM state enum, opcode constants, ALUControl / ResultSrc /
// ALUSrcA / ALUSrcB / ImmSrc encodings and the per-state control decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    // Opcodes the controller recognises
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUControl encodings (3-bit core, zero-extended at the top)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Control bundle produced for each state
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // Control values for a state; 'last' marks the final dwell cycle,
    // funct_alu is the funct-decoded ALU operation used by EXECR/EXECI.
    function automatic ctrl_t state_ctrl(input state_t s, input logic last,
                                         input logic [2:0] funct_alu);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (s)
            FETCH: begin
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
                c.pc_update  = last;
                c.ir_write   = last;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = last;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_ctrl  = funct_alu;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_ctrl  = funct_alu;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_ctrl  = ALU_SUB;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Immediate format selected purely by opcode
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // True for every opcode DECODE knows how to dispatch
    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: combinational funct3/funct7 to ALU operation decode.
// SUB is only chosen for register-register ops; addi with bit 30 set stays ADD.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [2:0] alu_ctrl
);

    // Map funct3 (and funct7 for R-type) onto the ALU encodings
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  alu_ctrl = (funct7 && (op == OP_RTYPE)) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            3'b010:  alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RISC-V style main controller.
// Optional feature macro: MC_CTRL_BNE_EN (funct3-qualified branch: beq/bne).
// Control outputs are registered from the next state so they line up with
// the state they belong to; only the Zero-dependent branch qualifier,
// Illegal and ImmSrc are combinational from the current instruction bits.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 Zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 Illegal,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
);

    // Wait count value of the final cycle of a memory dwell
    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] wait_reg;
    logic [3:0] wait_next;
    ctrl_t      ctrl_reg;
    ctrl_t      ctrl_next;
    logic [2:0] funct_alu;
    logic       dwell_done;
    logic       taken;

    alu_dec u_alu_dec (
        .op       (op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (funct_alu)
    );

    // Next state, dwell counter and the control word for that next state
    always_comb begin
        dwell_done = (wait_reg == LAST_WAIT);
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (dwell_done) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECR;
                    OP_ITYPE:     state_next = EXECI;
                    OP_JAL:       state_next = JAL;
                    OP_BRANCH:    state_next = BRANCH;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (dwell_done) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: if (dwell_done) state_next = FETCH;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            default:  state_next = FETCH;
        endcase
        // Every transition enters a different state, so staying put means dwelling
        wait_next = (state_next == state_reg) ? (wait_reg + 4'd1) : 4'd0;
        ctrl_next = state_ctrl(state_next, (wait_next == LAST_WAIT), funct_alu);
    end

    // State, dwell counter and registered control; reset aborts any access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            wait_reg  <= 4'd0;
            ctrl_reg  <= state_ctrl(FETCH, (LAST_WAIT == 4'd0), ALU_ADD);
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            ctrl_reg  <= ctrl_next;
        end
    end

`ifdef MC_CTRL_BNE_EN
    // Branch condition qualified by funct3: beq on Zero, bne on !Zero
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            default: taken = 1'b0;
        endcase
    end
`else
    // Only beq semantics: branch whenever the comparison is equal
    always_comb begin
        taken = Zero;
    end
`endif

    // Drive outputs from the registered control word and instruction bits
    always_comb begin
        PCWrite    = ctrl_reg.pc_update | (ctrl_reg.branch & taken);
        AdrSrc     = ctrl_reg.adr_src;
        MemWrite   = ctrl_reg.mem_write;
        IRWrite    = ctrl_reg.ir_write;
        RegWrite   = ctrl_reg.reg_write;
        ResultSrc  = ctrl_reg.result_src;
        ALUSrcA    = ctrl_reg.alu_src_a;
        ALUSrcB    = ctrl_reg.alu_src_b;
        ALUControl = ALUCTRL_W'(ctrl_reg.alu_ctrl);
        ImmSrc     = imm_src(op);
        Illegal    = (state_reg == DECODE) && !op_known(op);
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl with MEM_LAT=1 and MEM_LAT=3
// instances. Each instruction is expanded into the per-cycle output trace it
// must produce; a compare process checks the active instance every cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
    } exp_t;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst1;
    logic       rst3;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       sel;

    logic       d1_pcw, d1_adr, d1_mw, d1_irw, d1_rw, d1_ill;
    logic [1:0] d1_rs, d1_sa, d1_sb, d1_imm;
    logic [2:0] d1_alu;
    logic       d3_pcw, d3_adr, d3_mw, d3_irw, d3_rw, d3_ill;
    logic [1:0] d3_rs, d3_sa, d3_sb, d3_imm;
    logic [2:0] d3_alu;

    exp_t obs1, obs3;
    exp_t expq[$];
    exp_t genq[$];
    int   checks = 0;
    int   errors = 0;
    int   idx = 0;
    string tag = "reset";

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_LAT(1), .ALUCTRL_W(3)) dut1 (
        .clk(clk), .rst(rst1), .op(op), .funct3(funct3), .funct7(funct7), .Zero(zero),
        .PCWrite(d1_pcw), .AdrSrc(d1_adr), .MemWrite(d1_mw), .IRWrite(d1_irw),
        .RegWrite(d1_rw), .Illegal(d1_ill), .ResultSrc(d1_rs), .ALUSrcA(d1_sa),
        .ALUSrcB(d1_sb), .ImmSrc(d1_imm), .ALUControl(d1_alu)
    );

    mc_ctrl #(.MEM_LAT(3), .ALUCTRL_W(3)) dut3 (
        .clk(clk), .rst(rst3), .op(op), .funct3(funct3), .funct7(funct7), .Zero(zero),
        .PCWrite(d3_pcw), .AdrSrc(d3_adr), .MemWrite(d3_mw), .IRWrite(d3_irw),
        .RegWrite(d3_rw), .Illegal(d3_ill), .ResultSrc(d3_rs), .ALUSrcA(d3_sa),
        .ALUSrcB(d3_sb), .ImmSrc(d3_imm), .ALUControl(d3_alu)
    );

    assign obs1 = {d1_pcw, d1_adr, d1_mw, d1_irw, d1_rw, d1_ill, d1_rs, d1_sa, d1_sb, d1_imm, d1_alu};
    assign obs3 = {d3_pcw, d3_adr, d3_mw, d3_irw, d3_rw, d3_ill, d3_rs, d3_sa, d3_sb, d3_imm, d3_alu};

    function automatic string fmt(input exp_t e);
        return $sformatf("pcw=%b adr=%b mw=%b irw=%b rw=%b ill=%b rs=%b sa=%b sb=%b imm=%b alu=%b",
                         e.pcw, e.adr, e.mw, e.irw, e.rw, e.ill, e.rs, e.sa, e.sb, e.imm, e.alu);
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {%s} required {%s}", name, fmt(got), fmt(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_imm(input logic [6:0] o);
        if (o == T_SW)  return 2'b01;
        if (o == T_BR)  return 2'b10;
        if (o == T_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] m_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (f7 && o == T_R) ? 3'b001 : 3'b000;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b010) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z);
`ifdef MC_CTRL_BNE_EN
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        return 1'b0;
`else
        return z;
`endif
    endfunction

    function automatic exp_t blank(input logic [6:0] o);
        exp_t e;
        e = '0;
        e.imm = m_imm(o);
        return e;
    endfunction

    // Expand one instruction into its per-cycle output trace
    task automatic gen(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int lat);
        exp_t e;
        genq.delete();
        for (int i = 0; i < lat; i++) begin
            e = blank(o); e.sb = 2'b10; e.rs = 2'b10;
            if (i == lat - 1) begin e.irw = 1'b1; e.pcw = 1'b1; end
            genq.push_back(e);
        end
        e = blank(o); e.sa = 2'b01; e.sb = 2'b01;
        e.ill = !(o inside {T_LW, T_SW, T_R, T_I, T_JAL, T_BR});
        genq.push_back(e);
        if (o == T_LW || o == T_SW) begin
            e = blank(o); e.sa = 2'b10; e.sb = 2'b01; genq.push_back(e);
            for (int i = 0; i < lat; i++) begin
                e = blank(o); e.adr = 1'b1;
                if (o == T_SW && i == lat - 1) e.mw = 1'b1;
                genq.push_back(e);
            end
            if (o == T_LW) begin
                e = blank(o); e.rs = 2'b01; e.rw = 1'b1; genq.push_back(e);
            end
        end else if (o == T_R || o == T_I || o == T_JAL) begin
            e = blank(o);
            if (o == T_JAL) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            else begin e.sa = 2'b10; e.alu = m_alu(o, f3, f7); if (o == T_I) e.sb = 2'b01; end
            genq.push_back(e);
            e = blank(o); e.rw = 1'b1; genq.push_back(e);
        end else if (o == T_BR) begin
            e = blank(o); e.sa = 2'b10; e.alu = 3'b001; e.pcw = m_taken(f3, z);
            genq.push_back(e);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check($sformatf("%s cycle%0d", tag, idx + 1), sel ? obs3 : obs1, e);
            idx++;
        end
    end

    // Wait until the compare process consumed the trace; ends at posedge+1
    task automatic drain();
        int b;
        b = 0;
        while (expq.size() > 0 && b < 100) begin
            @(posedge clk);
            b++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d pending cycles required 0", tag, expq.size());
            expq.delete();
        end
        #1;
    endtask

    task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int lat);
        op = o; funct3 = f3; funct7 = f7; zero = z;
        gen(o, f3, f7, z, lat);
        tag = name;
        idx = 0;
        foreach (genq[i]) expq.push_back(genq[i]);
        $display("instr %-10s lat=%0d op=%b f3=%b f7=%b zero=%b cycles=%0d",
                 name, lat, o, f3, f7, z, genq.size());
        drain();
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        exp_t r;
        rst1 = 1'b1; rst3 = 1'b1; sel = 1'b0;
        op = T_LW; funct3 = 3'b010; funct7 = 1'b0; zero = 1'b0;

        // Model pins against hand-derived values
        gen(T_LW, 3'b010, 1'b0, 1'b0, 1);
        check_int("model lw len", genq.size(), 5);
        check_int("model lw c5 rw", int'(genq[4].rw), 1);
        check_int("model lw c5 rs", int'(genq[4].rs), 1);
        gen(T_R, 3'b000, 1'b1, 1'b0, 1);
        check_int("model sub alu", int'(genq[2].alu), 1);
        gen(T_SW, 3'b010, 1'b0, 1'b0, 3);
        check_int("model sw len", genq.size(), 8);
        check_int("model sw fetch1 irw", int'(genq[0].irw), 0);
        check_int("model sw fetch3 irw", int'(genq[2].irw), 1);
        check_int("model sw mw3", int'(genq[7].mw), 1);

        repeat (2) @(posedge clk);
        #1;
        // Reset state: FETCH; with MEM_LAT=1 that cycle is also the last one
        r = '0; r.sb = 2'b10; r.rs = 2'b10; r.pcw = 1'b1; r.irw = 1'b1;
        check("reset lat1", obs1, r);
        r.pcw = 1'b0; r.irw = 1'b0;
        check("reset lat3", obs3, r);

        // MEM_LAT=1 instance
        rst1 = 1'b0;
        run("lw",     T_LW,  3'b010, 1'b0, 1'b0, 1);
        run("sw",     T_SW,  3'b010, 1'b0, 1'b0, 1);
        run("add",    T_R,   3'b000, 1'b0, 1'b0, 1);
        run("sub",    T_R,   3'b000, 1'b1, 1'b0, 1);
        run("addi_f7", T_I,  3'b000, 1'b1, 1'b0, 1);
        run("and",    T_R,   3'b111, 1'b0, 1'b0, 1);
        run("ori",    T_I,   3'b110, 1'b0, 1'b0, 1);
        run("slt",    T_R,   3'b010, 1'b0, 1'b0, 1);
        run("xor_add", T_R,  3'b100, 1'b0, 1'b0, 1);
        run("beq_z1", T_BR,  3'b000, 1'b0, 1'b1, 1);
        run("beq_z0", T_BR,  3'b000, 1'b0, 1'b0, 1);
        run("bne_z0", T_BR,  3'b001, 1'b0, 1'b0, 1);
        run("bne_z1", T_BR,  3'b001, 1'b0, 1'b1, 1);
        run("blt_z1", T_BR,  3'b100, 1'b0, 1'b1, 1);
        run("jal",    T_JAL, 3'b000, 1'b0, 1'b0, 1);
        run("illegal", T_BAD, 3'b000, 1'b0, 1'b0, 1);
        run("lw_after", T_LW, 3'b010, 1'b0, 1'b0, 1);

        // MEM_LAT=3 instance
        rst1 = 1'b1; sel = 1'b1; rst3 = 1'b0;
        run("sw3",    T_SW,  3'b010, 1'b0, 1'b0, 3);
        run("lw3",    T_LW,  3'b010, 1'b0, 1'b0, 3);
        run("jal3",   T_JAL, 3'b000, 1'b0, 1'b0, 3);

        // Reset during the 2nd MEMREAD cycle of a lw
        op = T_LW; funct3 = 3'b010; funct7 = 1'b0; zero = 1'b0;
        gen(T_LW, 3'b010, 1'b0, 1'b0, 3);
        tag = "lw3_abort";
        idx = 0;
        for (int i = 0; i < 6; i++) expq.push_back(genq[i]);
        $display("instr %-10s lat=3 op=%b reset in 2nd MEMREAD cycle", "lw3_abort", T_LW);
        drain();
        rst3 = 1'b1;
        #1;
        r = '0; r.sb = 2'b10; r.rs = 2'b10;
        check("abort immediate", obs3, r);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort hold%0d", i + 1), obs3, r);
        end
        rst3 = 1'b0;
        run("sub3_post", T_R, 3'b000, 1'b1, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 1, memory access cycles per FETCH/MEMREAD/MEMWRITE; legal range 1..8.
REQ-002 Parameter ALUCTRL_W, default 3, ALUControl width; minimum 3.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Inputs: op (7, opcode); funct3 (3); funct7 (1, instr bit 30); Zero (1, ALU zero flag).
REQ-006 Outputs, 1 bit each: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal.
REQ-007 Outputs, 2 bits each: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc.
REQ-008 Output ALUControl, ALUCTRL_W bits.

Function
REQ-009 The state set SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-010 Transitions SHALL be:
  - FETCH->DECODE.
  - DECODE->MEMADR on lw/sw, EXECR on 0110011, EXECI on 0010011, JAL on 1101111, BRANCH on 1100011, else FETCH.
  - MEMADR->MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
  - EXECR, EXECI, JAL->ALUWB.
REQ-011 FETCH, MEMREAD and MEMWRITE SHALL dwell exactly MEM_LAT cycles each, tracked by a wait counter cleared on state entry; all other states last one cycle.
REQ-012 IRWrite and the PC update of FETCH SHALL assert only in FETCH's last cycle; MemWrite SHALL assert only in MEMWRITE's last cycle.
REQ-013 Per-state outputs SHALL be as follows; all unlisted outputs are 0:
  - FETCH: ALUSrcB=10, ResultSrc=10, PC update.
  - DECODE: ALUSrcA=01, ALUSrcB=01.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1.
  - EXECR: ALUSrcA=10, ALU op from funct.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU op from funct.
  - ALUWB: RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUControl=SUB, branch.
  - JAL: ALUSrcA=01, ALUSrcB=10, PC update.
REQ-014 PCWrite SHALL equal (PC update) OR (branch AND taken); taken is Zero, or as extended by REQ-021.
REQ-015 ALUControl encodings SHALL be ADD=000, SUB=001, AND=010, OR=011, SLT=101, zero-extended to ALUCTRL_W.
REQ-016 ALUControl SHALL be ADD in all states except EXECR/EXECI/BRANCH.
REQ-017 In EXECR/EXECI, ALUControl SHALL decode funct3: 000 gives SUB when funct7=1 and op=0110011, else ADD; 111 AND; 110 OR; 010 SLT; other codes ADD.
REQ-018 ImmSrc SHALL be decoded combinationally from op in every state: I/lw 00, sw 01, branch 10, jal 11, other 00.
REQ-019 Illegal SHALL pulse high for one cycle, in DECODE, for an unrecognised opcode; the FSM then returns to FETCH and writes no state.

Reset
REQ-020 rst SHALL force state=FETCH and wait counter=0 immediately; mid-access (any dwell cycle) rst SHALL abort with no IRWrite/MemWrite/RegWrite pulse; first FETCH after release SHALL last the full MEM_LAT cycles.

Configuration
REQ-021 Macro MC_CTRL_BNE_EN: when defined, BRANCH with funct3=001 SHALL be taken on Zero=0 and funct3=000 on Zero=1, and any other funct3 SHALL be not taken. When undefined, BRANCH SHALL be taken on Zero=1 regardless of funct3.

Structure
REQ-022 Package mc_ctrl_pkg SHALL hold the state enum, opcode constants, ALUControl encodings and ResultSrc/ALUSrc/ImmSrc encodings.
REQ-023 Sub-module alu_dec SHALL hold the combinational funct3/funct7-to-ALUControl decode, instantiated once.

Verification
REQ-024 MEM_LAT=1, lw (op=0000011): state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB in 5 cycles, with RegWrite=1 and ResultSrc=01 in cycle 5.
REQ-025 MEM_LAT=3, sw: FETCH lasts 3 cycles with IRWrite only in cycle 3; MemWrite=1 only in the 3rd MEMWRITE cycle.
REQ-026 R-type, funct3=000, funct7=1: ALUControl=001 in EXECR; funct7=0 gives 000; addi with funct7=1 gives 000.
REQ-027 beq: Zero=1 gives PCWrite=1 in BRANCH; Zero=0 gives PCWrite=0. With MC_CTRL_BNE_EN, funct3=001 and Zero=0 gives PCWrite=1.
REQ-028 op=1111111 gives Illegal=1 for one cycle and the next state is FETCH; rst asserted in the 2nd MEMREAD cycle (MEM_LAT=3) gives FETCH with no RegWrite pulse.
